brush_stamp_gen: RTL and testbench
==================================

// Module: brush_stamp_gen
// PURPOSE
//  Parametrised successor to the fixed radius-2 diamond membership test. On start, walks the
//  (2r+1)x(2r+1) bounding box around a centre point. Emits, in raster order, every coordinate
//  that is inside the selected brush shape and on screen, using a valid/ready stream.
//  Sits between the cursor/input logic and the framebuffer write port.
// PARAMETERS
//  COORD_W    16   signed coordinate width (cx, cy, out_x, out_y)
//  MAX_RADIUS 7    largest supported radius; larger requests are clamped to this
//  RAD_W      3    radius port width, >= $clog2(MAX_RADIUS+1)
//  SCREEN_W   640  valid x range is 0..SCREEN_W-1
//  SCREEN_H   480  valid y range is 0..SCREEN_H-1
//  CNT_W      8    width of stamp_count, >= $clog2((2*MAX_RADIUS+1)**2+1)
// PORTS
//  clock        in   1        single clock, all logic on posedge
//  reset        in   1        synchronous, active-high
//  start        in   1        request a stamp; sampled only in IDLE
//  cx, cy       in   COORD_W  signed centre; latched on accepted start
//  radius       in   RAD_W    brush radius; latched on accepted start
//  mode         in   2        0 diamond |dx|+|dy|<=r; 1 square; 2 ring |dx|+|dy|==r; 3 = diamond
//  busy         out  1        high in SCAN, EMIT and DONE
//  out_valid    out  1        out_x/out_y hold a point
//  out_ready    in   1        consumer accepts the point when out_valid && out_ready
//  out_x, out_y out  COORD_W  signed point coordinates
//  done         out  1        one-cycle pulse when the scan completes
//  stamp_count  out  CNT_W    points emitted by the current/last stamp; cleared on accepted start
// BEHAVIOUR
//  - Reset: state IDLE; busy, out_valid and done = 0; out_x, out_y and stamp_count = 0.
//    Reset mid-stamp aborts immediately, with no done pulse.
//  - States:
//    IDLE -(start)-> SCAN.
//    SCAN: evaluates one candidate (dx,dy) per cycle.
//      hit -> EMIT.
//      miss and not last -> advance, stay in SCAN.
//      miss and last -> DONE.
//    EMIT: out_valid=1, outputs held stable until the handshake.
//      On handshake: stamp_count++; then last -> DONE, else advance -> SCAN.
//    DONE: done=1 for one cycle -> IDLE.
//  - Scan order: dy from -r to +r (outer), dx from -r to +r (inner).
//    The first candidate is (-r,-r). The last candidate is (+r,+r).
//  - Latency: start accepted at edge N -> SCAN at N+1 -> out_valid at N+2 at the earliest.
//    Peak throughput is 1 point per 2 cycles.
//  - r_eff = min(radius, MAX_RADIUS). With r_eff=0 the single candidate is (0,0), a hit in
//    all modes, including ring.
//  - Point = (cx+dx, cy+dy), computed at COORD_W+1 bits (no wrap). Emitted only if
//    0 <= x < SCREEN_W and 0 <= y < SCREEN_H; otherwise treated as a miss.
//  - start while busy (including the DONE cycle) is ignored. cx, cy, radius and mode changing
//    mid-stamp have no effect.
//  - out_ready while out_valid=0 is ignored. done is never asserted together with out_valid.
//  - A stamp with zero on-screen points still passes through DONE (done pulse, stamp_count=0).
// STRUCTURE
//  - brush_pkg holds:
//    - mode constants MODE_DIAMOND=0, MODE_SQUARE=1, MODE_RING=2;
//    - state encoding IDLE/SCAN/EMIT/DONE.
//  - One sub-module, brush_shape_hit: combinational, takes (dx, dy, r_eff, mode) -> hit.
//    It is the parametrised generalisation of the radius membership test.
//  - The top level holds the FSM, the dx/dy counters, the clipping compare and the output
//    registers.
// TESTING
//  1. Diamond, r=2, centre (10,10), out_ready=1 -> exactly 13 points.
//     First (10,8), then (9,9),(10,9),(11,9); last (10,12); done pulse; stamp_count=13.
//  2. Square, r=1, centre (0,0) -> clipped to (0,0),(1,0),(0,1),(1,1) in that order;
//     stamp_count=4.
//  3. Ring, r=2, centre (50,50) -> 8 points, with (50,50) and (51,50) absent.
//     r=0 in ring mode -> the single point (50,50).
//  4. radius=7 diamond at (100,100), with out_ready low for 5 cycles on the 3rd point ->
//     out_x/out_y held stable while stalled; 113 points total; no duplicates or drops.
//  5. Assert reset in the EMIT state of test 1 -> next cycle busy, out_valid=0; no done pulse.
//     A fresh start then reproduces test 1 exactly.
//  6. start pulsed during SCAN and during DONE -> ignored.
//     Centre (-5,-5), r=2 -> 0 points, done pulse, stamp_count=0.

Source files
------------

// File: rtl/brush_pkg.sv
// brush_pkg
//   Shared definitions for the brush stamp generator.
//   - Brush mode codes driven on the mode port (code 3 is treated as diamond).
//   - FSM state encoding used by brush_stamp_gen.
package brush_pkg;

    localparam logic [1:0] MODE_DIAMOND = 2'd0;
    localparam logic [1:0] MODE_SQUARE  = 2'd1;
    localparam logic [1:0] MODE_RING    = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_EMIT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/brush_shape_hit.sv
// brush_shape_hit
//   Combinational brush membership test for one candidate offset.
//   Ports:
//     i_dx, i_dy  in  RAD_W+1  signed offset from the brush centre
//     i_r_eff     in  RAD_W    effective (already clamped) radius
//     i_mode      in  2        brush shape code (see brush_pkg)
//     o_hit       out 1        offset lies inside the selected shape
//   The caller only presents offsets inside the (2r+1)x(2r+1) box, so the
//   square shape is a hit for every candidate it is given.
module brush_shape_hit
    import brush_pkg::*;
#(
    parameter int RAD_W = 3
) (
    input  logic signed [RAD_W:0]   i_dx,
    input  logic signed [RAD_W:0]   i_dy,
    input  logic        [RAD_W-1:0] i_r_eff,
    input  logic        [1:0]       i_mode,
    output logic                    o_hit
);

    logic [RAD_W:0]   w_adx;
    logic [RAD_W:0]   w_ady;
    logic [RAD_W+1:0] w_sum;
    logic [RAD_W+1:0] w_r;

    assign w_adx = i_dx[RAD_W] ? -i_dx : i_dx;
    assign w_ady = i_dy[RAD_W] ? -i_dy : i_dy;
    assign w_sum = {1'b0, w_adx} + {1'b0, w_ady};
    assign w_r   = {2'b00, i_r_eff};

    always_comb begin
        o_hit = 1'b0;
        case (i_mode)
            MODE_SQUARE: o_hit = 1'b1;
            MODE_RING:   o_hit = (w_sum == w_r);
            default:     o_hit = (w_sum <= w_r);
        endcase
    end

endmodule

// File: rtl/brush_stamp_gen.sv
// brush_stamp_gen
//   Walks the (2r+1)x(2r+1) box around a centre point in raster order and
//   streams every on-screen coordinate that lies inside the selected brush.
//   Ports:
//     clock, reset        clock and synchronous active-high reset
//     start               stamp request, sampled only in IDLE
//     cx, cy              signed centre, latched on accepted start
//     radius, mode        brush radius and shape, latched on accepted start
//     busy                high in SCAN, EMIT and DONE
//     out_valid/out_ready point stream handshake
//     out_x, out_y        signed point coordinates
//     done                one-cycle pulse when the scan completes
//     stamp_count         points emitted by the current/last stamp
module brush_stamp_gen
    import brush_pkg::*;
#(
    parameter int COORD_W    = 16,
    parameter int MAX_RADIUS = 7,
    parameter int RAD_W      = 3,
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int CNT_W      = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic signed [COORD_W-1:0] cx,
    input  logic signed [COORD_W-1:0] cy,
    input  logic        [RAD_W-1:0]   radius,
    input  logic        [1:0]         mode,
    output logic                      busy,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [COORD_W-1:0] out_x,
    output logic signed [COORD_W-1:0] out_y,
    output logic                      done,
    output logic        [CNT_W-1:0]   stamp_count
);

    localparam logic [RAD_W-1:0]          LP_RMAX = RAD_W'(MAX_RADIUS);
    localparam logic signed [COORD_W:0]   LP_SW   = (COORD_W+1)'(SCREEN_W);
    localparam logic signed [COORD_W:0]   LP_SH   = (COORD_W+1)'(SCREEN_H);
    localparam logic signed [RAD_W:0]     LP_ONE  = (RAD_W+1)'(1);

    state_t                    r_state;
    state_t                    w_next;
    logic signed [COORD_W-1:0] r_cx;
    logic signed [COORD_W-1:0] r_cy;
    logic        [RAD_W-1:0]   r_r;
    logic        [1:0]         r_mode;
    logic signed [RAD_W:0]     r_dx;
    logic signed [RAD_W:0]     r_dy;
    logic signed [COORD_W-1:0] r_out_x;
    logic signed [COORD_W-1:0] r_out_y;
    logic        [CNT_W-1:0]   r_count;

    logic        [RAD_W-1:0]   w_r_eff;
    logic signed [RAD_W:0]     w_neg_r_eff;
    logic signed [RAD_W:0]     w_rs;
    logic signed [COORD_W:0]   w_px;
    logic signed [COORD_W:0]   w_py;
    logic                      w_on_screen;
    logic                      w_hit;
    logic                      w_take;
    logic                      w_last;
    logic                      w_accept;
    logic                      w_load;
    logic                      w_adv;
    logic                      w_hs;

    assign w_r_eff     = (radius > LP_RMAX) ? LP_RMAX : radius;
    assign w_neg_r_eff = -$signed({1'b0, w_r_eff});
    assign w_rs        = $signed({1'b0, r_r});
    assign w_last      = (r_dx == w_rs) && (r_dy == w_rs);

    // One extra bit so centres near the coordinate limits cannot wrap onto the screen.
    assign w_px = (COORD_W+1)'(r_cx) + (COORD_W+1)'(r_dx);
    assign w_py = (COORD_W+1)'(r_cy) + (COORD_W+1)'(r_dy);
    assign w_on_screen = !w_px[COORD_W] && (w_px < LP_SW) &&
                         !w_py[COORD_W] && (w_py < LP_SH);

    brush_shape_hit #(.RAD_W(RAD_W)) u_shape (
        .i_dx    (r_dx),
        .i_dy    (r_dy),
        .i_r_eff (r_r),
        .i_mode  (r_mode),
        .o_hit   (w_hit)
    );

    assign w_take = w_hit && w_on_screen;

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_load   = 1'b0;
        w_adv    = 1'b0;
        w_hs     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (w_take) begin
                    w_load = 1'b1;
                    w_next = ST_EMIT;
                end else if (w_last) begin
                    w_next = ST_DONE;
                end else begin
                    w_adv = 1'b1;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    w_hs = 1'b1;
                    if (w_last) begin
                        w_next = ST_DONE;
                    end else begin
                        w_adv  = 1'b1;
                        w_next = ST_SCAN;
                    end
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cx    <= '0;
            r_cy    <= '0;
            r_r     <= '0;
            r_mode  <= '0;
            r_dx    <= '0;
            r_dy    <= '0;
            r_out_x <= '0;
            r_out_y <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_cx    <= cx;
                r_cy    <= cy;
                r_r     <= w_r_eff;
                r_mode  <= mode;
                r_dx    <= w_neg_r_eff;
                r_dy    <= w_neg_r_eff;
                r_count <= '0;
            end
            if (w_load) begin
                r_out_x <= w_px[COORD_W-1:0];
                r_out_y <= w_py[COORD_W-1:0];
            end
            if (w_hs) begin
                r_count <= r_count + CNT_W'(1);
            end
            if (w_adv) begin
                if (r_dx == w_rs) begin
                    r_dx <= -w_rs;
                    r_dy <= r_dy + LP_ONE;
                end else begin
                    r_dx <= r_dx + LP_ONE;
                end
            end
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign out_valid   = (r_state == ST_EMIT);
    assign done        = (r_state == ST_DONE);
    assign out_x       = r_out_x;
    assign out_y       = r_out_y;
    assign stamp_count = r_count;

endmodule

// File: tb/tb_brush_stamp_gen.sv
module tb_brush_stamp_gen;

    logic               clock;
    logic               reset;
    logic               start;
    logic signed [15:0] cx;
    logic signed [15:0] cy;
    logic        [2:0]  radius;
    logic        [1:0]  mode;
    logic               busy;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_x;
    logic signed [15:0] out_y;
    logic               done;
    logic        [7:0]  stamp_count;

    int n_pass  = 0;
    int n_total = 0;

    brush_stamp_gen #(
        .COORD_W    (16),
        .MAX_RADIUS (7),
        .RAD_W      (3),
        .SCREEN_W   (640),
        .SCREEN_H   (480),
        .CNT_W      (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .cx          (cx),
        .cy          (cy),
        .radius      (radius),
        .mode        (mode),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_x       (out_x),
        .out_y       (out_y),
        .done        (done),
        .stamp_count (stamp_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] mode;
        int         radius;
        int         cx;
        int         cy;
        int         stall_at;
        int         exp_cnt;
        int         fx;
        int         fy;
        int         lx;
        int         ly;
    } vec_t;

    vec_t tv[10];
    int   gx[$];
    int   gy[$];
    int   ex[$];
    int   ey[$];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic build_exp(input logic [1:0] m, input int r, input int ccx, input int ccy);
        int s;
        bit in_shape;
        ex.delete();
        ey.delete();
        for (int dy = -r; dy <= r; dy++) begin
            for (int dx = -r; dx <= r; dx++) begin
                s = (dx < 0 ? -dx : dx) + (dy < 0 ? -dy : dy);
                if (m == 2'd1)      in_shape = 1'b1;
                else if (m == 2'd2) in_shape = (s == r);
                else                in_shape = (s <= r);
                if (in_shape && ccx + dx >= 0 && ccx + dx < 640 &&
                    ccy + dy >= 0 && ccy + dy < 480) begin
                    ex.push_back(ccx + dx);
                    ey.push_back(ccy + dy);
                end
            end
        end
    endtask

    task automatic pulse_start(input logic [1:0] m, input int r, input int ccx, input int ccy);
        @(negedge clock);
        mode   = m;
        radius = 3'(r);
        cx     = 16'(ccx);
        cy     = 16'(ccy);
        start  = 1'b1;
        @(negedge clock);
        start  = 1'b0;
        // Scramble the inputs: a latched stamp must not see these.
        mode   = 2'd1;
        radius = 3'd0;
        cx     = -16'sd300;
        cy     = 16'sd7;
    endtask

    task automatic run_stamp(input string tag, input vec_t v);
        int  stall;
        int  hold_x;
        int  hold_y;
        int  moved;
        int  overlap;
        int  seen_done;
        int  mism;
        gx.delete();
        gy.delete();
        stall     = 0;
        hold_x    = 0;
        hold_y    = 0;
        moved     = 0;
        overlap   = 0;
        seen_done = 0;
        pulse_start(v.mode, v.radius, v.cx, v.cy);
        for (int cyc = 0; cyc < 2000; cyc++) begin
            out_ready = 1'b1;
            if (out_valid && gx.size() == v.stall_at && stall < 5) begin
                out_ready = 1'b0;
                if (stall == 0) begin
                    hold_x = int'(out_x);
                    hold_y = int'(out_y);
                end else if (int'(out_x) != hold_x || int'(out_y) != hold_y) begin
                    moved++;
                end
                stall++;
            end
            if (done && out_valid) overlap++;
            if (out_valid && out_ready) begin
                gx.push_back(int'(out_x));
                gy.push_back(int'(out_y));
            end
            if (done) begin
                seen_done = 1;
                break;
            end
            @(negedge clock);
        end
        check({tag, "_done_seen"}, seen_done, 1);
        check({tag, "_count"}, gx.size(), v.exp_cnt);
        check({tag, "_stamp_count"}, int'(stamp_count), v.exp_cnt);
        check({tag, "_done_vs_valid"}, overlap, 0);
        if (v.exp_cnt > 0 && gx.size() > 0) begin
            check({tag, "_first_x"}, gx[0], v.fx);
            check({tag, "_first_y"}, gy[0], v.fy);
            check({tag, "_last_x"}, gx[gx.size()-1], v.lx);
            check({tag, "_last_y"}, gy[gy.size()-1], v.ly);
        end
        if (v.stall_at >= 0) begin
            check({tag, "_stall_len"}, stall, 5);
            check({tag, "_stall_hold"}, moved, 0);
        end
        build_exp(v.mode, v.radius, v.cx, v.cy);
        mism = 0;
        for (int i = 0; i < gx.size() && i < ex.size(); i++) begin
            if (gx[i] != ex[i] || gy[i] != ey[i]) mism++;
        end
        check({tag, "_model_len"}, gx.size(), ex.size());
        check({tag, "_model_seq"}, mism, 0);
        @(negedge clock);
        check({tag, "_done_one_cycle"}, int'(done), 0);
        check({tag, "_idle_after"}, int'(busy), 0);
    endtask

    initial begin
        int seen;
        int hit;

        //            mode  r  cx    cy   stall cnt  fx   fy   lx   ly
        tv[0] = '{2'd0, 2,  10,   10,  -1,   13,  10,  8,   10,  12};
        tv[1] = '{2'd1, 1,   0,    0,  -1,    4,   0,  0,    1,   1};
        tv[2] = '{2'd2, 2,  50,   50,  -1,    8,  50, 48,   50,  52};
        tv[3] = '{2'd2, 0,  50,   50,  -1,    1,  50, 50,   50,  50};
        tv[4] = '{2'd0, 7, 100,  100,   2,  113, 100, 93,  100, 107};
        tv[5] = '{2'd0, 2,  -5,   -5,  -1,    0,   0,  0,    0,   0};
        tv[6] = '{2'd3, 1,   5,    5,  -1,    5,   5,  4,    5,   6};
        tv[7] = '{2'd1, 2, 639,  479,  -1,    9, 637, 477, 639, 479};
        tv[8] = '{2'd0, 1,   0,    5,  -1,    4,   0,  4,    0,   6};
        tv[9] = '{2'd1, 0, 639,    0,  -1,    1, 639,  0,  639,   0};

        reset     = 1'b1;
        start     = 1'b0;
        cx        = '0;
        cy        = '0;
        radius    = '0;
        mode      = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_done", int'(done), 0);
        check("rst_out_x", int'(out_x), 0);
        check("rst_out_y", int'(out_y), 0);
        check("rst_stamp_count", int'(stamp_count), 0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_stamp($sformatf("vec%0d", i), tv[i]);
        end

        // Earliest output: ring r=0 yields its one point two cycles after start.
        out_ready = 1'b0;
        pulse_start(2'd2, 0, 50, 50);
        check("lat_busy", int'(busy), 1);
        check("lat_valid_early", int'(out_valid), 0);
        @(negedge clock);
        check("lat_valid", int'(out_valid), 1);
        check("lat_x", int'(out_x), 50);
        check("lat_y", int'(out_y), 50);
        out_ready = 1'b1;
        @(negedge clock);
        check("lat_valid_after", int'(out_valid), 0);
        check("lat_done", int'(done), 1);
        check("lat_count", int'(stamp_count), 1);
        @(negedge clock);
        check("lat_idle", int'(busy), 0);

        // Reset while a point is waiting in EMIT.
        out_ready = 1'b0;
        pulse_start(2'd0, 2, 10, 10);
        hit = 0;
        for (int c = 0; c < 50; c++) begin
            if (out_valid) begin
                hit = 1;
                break;
            end
            @(negedge clock);
        end
        check("rstmid_reached_emit", hit, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rstmid_busy", int'(busy), 0);
        check("rstmid_valid", int'(out_valid), 0);
        check("rstmid_count", int'(stamp_count), 0);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (done) seen++;
            @(negedge clock);
        end
        check("rstmid_no_done", seen, 0);
        run_stamp("rerun", tv[0]);

        // Start pulses during SCAN and DONE must be ignored.
        out_ready = 1'b1;
        pulse_start(2'd0, 2, -5, -5);
        check("ign_in_scan", int'(busy), 1);
        mode   = 2'd0;
        radius = 3'd2;
        cx     = 16'sd10;
        cy     = 16'sd10;
        start  = 1'b1;
        @(negedge clock);
        start  = 1'b0;
        seen   = 0;
        for (int c = 0; c < 100; c++) begin
            if (out_valid) seen++;
            if (done) break;
            @(negedge clock);
        end
        check("ign_done_reached", int'(done), 1);
        check("ign_no_points", seen, 0);
        check("ign_count", int'(stamp_count), 0);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("ign_after_done_busy", int'(busy), 0);
        @(negedge clock);
        check("ign_still_idle", int'(busy), 0);
        check("ign_count_kept", int'(stamp_count), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
